// File: rtl/dps_bus_pkg.sv
// Shared constants, state encodings and helpers for the DPS bus router.
package dps_bus_pkg;

    localparam int unsigned DATA_W = 32;

    // Access FSM encodings
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] ERR_RSP = 2'd2;

    // IRQ FSM encodings
    localparam logic [0:0] IRQ_IDLE = 1'b0;
    localparam logic [0:0] IRQ_WAIT = 1'b1;

    // Data returned with an error response
    localparam logic [DATA_W-1:0] ERR_DATA = 32'h0;

    // Upstream response payload
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } dpsRsp_t;

    // Ceiling log2, minimum result 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned n = 1; n < value; n = n << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dps_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, with wrap-around.
module dps_rr_arbiter
    import dps_bus_pkg::*;
#(
    parameter int unsigned P_DEV_NUM = 4,
    parameter int unsigned P_IDX_W   = clog2(P_DEV_NUM)
) (
    input  logic [P_DEV_NUM-1:0] iREQ,
    input  logic [P_IDX_W-1:0]   iPTR,
    output logic [P_IDX_W-1:0]   oGRANT,
    output logic                 oVALID
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        logic [P_IDX_W-1:0] cand;
        cand   = '0;
        oGRANT = '0;
        oVALID = 1'b0;
        for (int i = int'(P_DEV_NUM) - 1; i >= 0; i--) begin
            cand = P_IDX_W'((int'(iPTR) + i) % int'(P_DEV_NUM));
            if (iREQ[cand]) begin
                oGRANT = cand;
                oVALID = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dps_bus_router.sv
// DPS front end: address-decoded slot routing, single outstanding read with
// timeout and unmapped-error responses, and round-robin IRQ forwarding.
module dps_bus_router
    import dps_bus_pkg::*;
#(
    parameter int unsigned P_DEV_NUM    = 4,
    parameter int unsigned P_SLOT_SHIFT = 8,
    parameter int unsigned P_TIMEOUT    = 255,
    parameter logic [5:0]  P_IRQ_BASE   = 6'h36
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    input  logic                          iDPS_REQ,
    output logic                          oDPS_BUSY,
    input  logic                          iDPS_RW,
    input  logic [31:0]                   iDPS_ADDR,
    input  logic [31:0]                   iDPS_DATA,
    output logic                          oDPS_VALID,
    output logic [31:0]                   oDPS_DATA,
    output logic                          oDPS_ERR,
    output logic [P_DEV_NUM-1:0]          oDEV_REQ,
    input  logic [P_DEV_NUM-1:0]          iDEV_BUSY,
    output logic                          oDEV_RW,
    output logic [P_SLOT_SHIFT-3:0]       oDEV_ADDR,
    output logic [31:0]                   oDEV_DATA,
    input  logic [P_DEV_NUM-1:0]          iDEV_VALID,
    input  logic [32*P_DEV_NUM-1:0]       iDEV_DATA,
    input  logic [P_DEV_NUM-1:0]          iDEV_IRQ,
    output logic [P_DEV_NUM-1:0]          oDEV_IRQ_ACK,
    output logic                          oDPS_IRQ_REQ,
    output logic [5:0]                    oDPS_IRQ_NUM,
    input  logic                          iDPS_IRQ_ACK
);

    localparam int unsigned IDX_W = clog2(P_DEV_NUM);
    localparam int unsigned CNT_W = clog2(P_TIMEOUT + 1);

    // Decode and handshake
    logic [31:0]          slotFull;
    logic [IDX_W-1:0]     slotIdx;
    logic                 mapped;
    logic                 busy;
    logic                 accept;
    logic [31:0]          devWord [P_DEV_NUM];

    // Access FSM
    logic [1:0]           accState, accStateNext;
    logic [CNT_W-1:0]     rdCnt, rdCntNext;
    logic [IDX_W-1:0]     stamp, stampNext;
    logic                 rspValid, rspValidNext;
    dpsRsp_t              rsp, rspNext;

    // IRQ FSM
    logic [0:0]           irqState, irqStateNext;
    logic [IDX_W-1:0]     irqGnt, irqGntNext;
    logic [IDX_W-1:0]     rrPtr, rrPtrNext;
    logic                 irqReq, irqReqNext;
    logic [5:0]           irqNum, irqNumNext;
    logic [P_DEV_NUM-1:0] irqAck, irqAckNext;
    logic [IDX_W-1:0]     arbGrant;
    logic                 arbValid;

    assign slotFull  = iDPS_ADDR >> P_SLOT_SHIFT;
    assign slotIdx   = IDX_W'(slotFull);
    assign mapped    = slotFull < 32'(P_DEV_NUM);
    assign busy      = (accState != IDLE) | (|iDEV_BUSY);
    assign accept    = iDPS_REQ & ~busy;

    assign oDPS_BUSY = busy;
    assign oDEV_RW   = iDPS_RW;
    assign oDEV_DATA = iDPS_DATA;
    assign oDEV_ADDR = iDPS_ADDR[P_SLOT_SHIFT-1:2];

    for (genvar k = 0; k < P_DEV_NUM; k++) begin : g_unpack
        assign devWord[k] = iDEV_DATA[32*k +: 32];
    end

    // One-hot slot strobe on an accepted, mapped request
    always_comb begin
        oDEV_REQ = '0;
        if (accept && mapped) begin
            oDEV_REQ[slotIdx] = 1'b1;
        end
    end

    // Access FSM next state: read tracking, timeout, error responses
    always_comb begin
        accStateNext = accState;
        rdCntNext    = rdCnt;
        stampNext    = stamp;
        rspValidNext = 1'b0;
        rspNext      = rsp;
        case (accState)
            IDLE: begin
                if (accept && !iDPS_RW) begin
                    if (mapped) begin
                        accStateNext = RD_WAIT;
                        stampNext    = slotIdx;
                        rdCntNext    = '0;
                    end else begin
                        accStateNext = ERR_RSP;
                        rspValidNext = 1'b1;
                        rspNext      = '{err: 1'b1, data: ERR_DATA};
                    end
                end
            end
            RD_WAIT: begin
                // Device valid takes priority over the timeout on the last wait cycle
                if (iDEV_VALID[stamp]) begin
                    accStateNext = IDLE;
                    rspValidNext = 1'b1;
                    rspNext      = '{err: 1'b0, data: devWord[stamp]};
                end else begin
                    rdCntNext = rdCnt + CNT_W'(1);
                    if (rdCnt == CNT_W'(P_TIMEOUT - 1)) begin
                        accStateNext = ERR_RSP;
                        rspValidNext = 1'b1;
                        rspNext      = '{err: 1'b1, data: ERR_DATA};
                    end
                end
            end
            ERR_RSP: begin
                accStateNext = IDLE;
            end
            default: begin
                accStateNext = IDLE;
            end
        endcase
    end

    // Access FSM state and response registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            accState <= IDLE;
            rdCnt    <= '0;
            stamp    <= '0;
            rspValid <= 1'b0;
            rsp      <= '0;
        end else begin
            accState <= accStateNext;
            rdCnt    <= rdCntNext;
            stamp    <= stampNext;
            rspValid <= rspValidNext;
            rsp      <= rspNext;
        end
    end

    assign oDPS_VALID = rspValid;
    assign oDPS_DATA  = rsp.data;
    assign oDPS_ERR   = rsp.err;

    dps_rr_arbiter #(
        .P_DEV_NUM (P_DEV_NUM),
        .P_IDX_W   (IDX_W)
    ) u_arb (
        .iREQ   (iDEV_IRQ),
        .iPTR   (rrPtr),
        .oGRANT (arbGrant),
        .oVALID (arbValid)
    );

    // IRQ FSM next state: grant, hold until core ack, advance pointer
    always_comb begin
        irqStateNext = irqState;
        irqGntNext   = irqGnt;
        rrPtrNext    = rrPtr;
        irqReqNext   = irqReq;
        irqNumNext   = irqNum;
        irqAckNext   = '0;
        case (irqState)
            IRQ_IDLE: begin
                if (arbValid) begin
                    irqStateNext = IRQ_WAIT;
                    irqGntNext   = arbGrant;
                    irqReqNext   = 1'b1;
                    irqNumNext   = P_IRQ_BASE + 6'(arbGrant);
                end
            end
            IRQ_WAIT: begin
                if (iDPS_IRQ_ACK) begin
                    irqStateNext       = IRQ_IDLE;
                    irqReqNext         = 1'b0;
                    irqAckNext[irqGnt] = 1'b1;
                    rrPtrNext          = (irqGnt == IDX_W'(P_DEV_NUM - 1)) ? '0
                                                                           : irqGnt + IDX_W'(1);
                end
            end
            default: begin
                irqStateNext = IRQ_IDLE;
            end
        endcase
    end

    // IRQ FSM state and output registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            irqState <= IRQ_IDLE;
            irqGnt   <= '0;
            rrPtr    <= '0;
            irqReq   <= 1'b0;
            irqNum   <= P_IRQ_BASE;
            irqAck   <= '0;
        end else begin
            irqState <= irqStateNext;
            irqGnt   <= irqGntNext;
            rrPtr    <= rrPtrNext;
            irqReq   <= irqReqNext;
            irqNum   <= irqNumNext;
            irqAck   <= irqAckNext;
        end
    end

    assign oDPS_IRQ_REQ = irqReq;
    assign oDPS_IRQ_NUM = irqNum;
    assign oDEV_IRQ_ACK = irqAck;

endmodule

// File: tb/tb_dps_bus_router.sv
// Self-checking bench for dps_bus_router: decode table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_dps_bus_router;

    localparam int N   = 4;
    localparam int SH  = 8;
    localparam int TMO = 8;
    localparam logic [5:0] BASE = 6'h36;

    logic            iCLOCK;
    logic            inRESET;
    logic            iDPS_REQ;
    logic            oDPS_BUSY;
    logic            iDPS_RW;
    logic [31:0]     iDPS_ADDR;
    logic [31:0]     iDPS_DATA;
    logic            oDPS_VALID;
    logic [31:0]     oDPS_DATA;
    logic            oDPS_ERR;
    logic [N-1:0]    oDEV_REQ;
    logic [N-1:0]    iDEV_BUSY;
    logic            oDEV_RW;
    logic [SH-3:0]   oDEV_ADDR;
    logic [31:0]     oDEV_DATA;
    logic [N-1:0]    iDEV_VALID;
    logic [32*N-1:0] iDEV_DATA;
    logic [N-1:0]    iDEV_IRQ;
    logic [N-1:0]    oDEV_IRQ_ACK;
    logic            oDPS_IRQ_REQ;
    logic [5:0]      oDPS_IRQ_NUM;
    logic            iDPS_IRQ_ACK;

    int nAssert = 0;
    int nFail   = 0;
    int rrModel = 0;

    dps_bus_router #(
        .P_DEV_NUM    (N),
        .P_SLOT_SHIFT (SH),
        .P_TIMEOUT    (TMO),
        .P_IRQ_BASE   (BASE)
    ) dut (
        .iCLOCK       (iCLOCK),
        .inRESET      (inRESET),
        .iDPS_REQ     (iDPS_REQ),
        .oDPS_BUSY    (oDPS_BUSY),
        .iDPS_RW      (iDPS_RW),
        .iDPS_ADDR    (iDPS_ADDR),
        .iDPS_DATA    (iDPS_DATA),
        .oDPS_VALID   (oDPS_VALID),
        .oDPS_DATA    (oDPS_DATA),
        .oDPS_ERR     (oDPS_ERR),
        .oDEV_REQ     (oDEV_REQ),
        .iDEV_BUSY    (iDEV_BUSY),
        .oDEV_RW      (oDEV_RW),
        .oDEV_ADDR    (oDEV_ADDR),
        .oDEV_DATA    (oDEV_DATA),
        .iDEV_VALID   (iDEV_VALID),
        .iDEV_DATA    (iDEV_DATA),
        .iDEV_IRQ     (iDEV_IRQ),
        .oDEV_IRQ_ACK (oDEV_IRQ_ACK),
        .oDPS_IRQ_REQ (oDPS_IRQ_REQ),
        .oDPS_IRQ_NUM (oDPS_IRQ_NUM),
        .iDPS_IRQ_ACK (iDPS_IRQ_ACK)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic         rw;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [N-1:0] devBusy;
        logic         expBusy;
        logic [N-1:0] expReq;
        logic [5:0]   expAddr;
        logic         expRsp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    function automatic bit isMapped(input logic [31:0] a);
        return (a >> SH) < 32'(N);
    endfunction

    function automatic logic [N-1:0] reqOf(input logic [31:0] a);
        logic [N-1:0] r;
        r = '0;
        if (isMapped(a)) r[int'(a >> SH)] = 1'b1;
        return r;
    endfunction

    function automatic int rrPick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Read transaction: device answers after d wait cycles (d >= TMO means too late)
    task automatic doRead(input logic [31:0] addr, input int d, input logic [31:0] dat);
        bit           mapped;
        int           slot;
        int           expOff;
        int           kEnd;
        bit           expErr;
        logic [31:0]  expData;
        mapped = isMapped(addr);
        slot   = mapped ? int'(addr >> SH) : 0;
        if (!mapped) begin
            expOff = 1; expErr = 1'b1; expData = 32'h0;
        end else if (d < TMO) begin
            expOff = d + 2; expErr = 1'b0; expData = dat;
        end else begin
            expOff = TMO + 1; expErr = 1'b1; expData = 32'h0;
        end
        kEnd = ((expOff > d + 1) ? expOff : d + 1) + 1;
        iDPS_REQ  = 1'b1;
        iDPS_RW   = 1'b0;
        iDPS_ADDR = addr;
        iDPS_DATA = $urandom;
        #1;
        chk("rd_busy_idle", 64'(oDPS_BUSY), 64'(0));
        chk("rd_dev_req", 64'(oDEV_REQ), 64'(reqOf(addr)));
        chk("rd_dev_addr", 64'(oDEV_ADDR), 64'(addr[SH-1:2]));
        for (int k = 1; k <= kEnd; k++) begin
            tick();
            iDPS_REQ = 1'b0;
            if (k == 1) chk("rd_busy_wait", 64'(oDPS_BUSY), 64'(1));
            chk("rd_valid", 64'(oDPS_VALID), 64'(k == expOff));
            if (k == expOff || k == expOff + 1) begin
                chk("rd_err", 64'(oDPS_ERR), 64'(expErr));
                chk("rd_data", 64'(oDPS_DATA), 64'(expData));
            end
            iDEV_VALID = N'($urandom);
            iDEV_DATA  = {$urandom, $urandom, $urandom, $urandom};
            if (mapped) begin
                iDEV_VALID[slot] = (k - 1 == d);
                if (k - 1 == d) iDEV_DATA[32*slot +: 32] = dat;
            end
        end
        iDEV_VALID = '0;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] dat);
        iDPS_REQ  = 1'b1;
        iDPS_RW   = 1'b1;
        iDPS_ADDR = addr;
        iDPS_DATA = dat;
        #1;
        chk("wr_busy", 64'(oDPS_BUSY), 64'(0));
        chk("wr_dev_req", 64'(oDEV_REQ), 64'(reqOf(addr)));
        chk("wr_dev_rw", 64'(oDEV_RW), 64'(1));
        chk("wr_dev_data", 64'(oDEV_DATA), 64'(dat));
        chk("wr_dev_addr", 64'(oDEV_ADDR), 64'(addr[SH-1:2]));
        tick();
        iDPS_REQ = 1'b0;
        chk("wr_no_rsp", 64'(oDPS_VALID), 64'(0));
        tick();
        chk("wr_no_rsp2", 64'(oDPS_VALID), 64'(0));
    endtask

    task automatic accessRandom(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & 32'h7FF;
            if ($urandom_range(0, 9) < 3) doWrite(a, $urandom);
            else doRead(a, int'($urandom_range(0, TMO + 2)), $urandom);
        end
    endtask

    task automatic irqRandom(input int n);
        logic [N-1:0] v;
        int           g;
        int           dly;
        for (int i = 0; i < n; i++) begin
            v = N'($urandom_range(1, 15));
            g = rrPick(v, rrModel);
            iDEV_IRQ = v;
            tick();
            chk("irq_req", 64'(oDPS_IRQ_REQ), 64'(1));
            chk("irq_num", 64'(oDPS_IRQ_NUM), 64'(BASE + 6'(g)));
            dly = int'($urandom_range(0, 3));
            for (int c = 0; c < dly; c++) begin
                iDEV_IRQ = N'($urandom);
                tick();
                chk("irq_hold_req", 64'(oDPS_IRQ_REQ), 64'(1));
                chk("irq_hold_num", 64'(oDPS_IRQ_NUM), 64'(BASE + 6'(g)));
                chk("irq_hold_ack", 64'(oDEV_IRQ_ACK), 64'(0));
            end
            iDPS_IRQ_ACK = 1'b1;
            iDEV_IRQ     = '0;
            tick();
            iDPS_IRQ_ACK = 1'b0;
            chk("irq_ack_pulse", 64'(oDEV_IRQ_ACK), 64'(1) << g);
            chk("irq_req_drop", 64'(oDPS_IRQ_REQ), 64'(0));
            rrModel = (g + 1) % N;
        end
    endtask

    vec_t         vecs [8];
    logic [5:0]   expNum [3];
    logic [N-1:0] expAck [3];

    initial begin
        iDPS_REQ = 0; iDPS_RW = 0; iDPS_ADDR = 0; iDPS_DATA = 0;
        iDEV_BUSY = 0; iDEV_VALID = 0; iDEV_DATA = 0; iDEV_IRQ = 0; iDPS_IRQ_ACK = 0;
        inRESET = 1'b1;
        #1 inRESET = 1'b0;
        #1;
        chk("rst_valid", 64'(oDPS_VALID), 64'(0));
        chk("rst_data", 64'(oDPS_DATA), 64'(0));
        chk("rst_err", 64'(oDPS_ERR), 64'(0));
        chk("rst_busy", 64'(oDPS_BUSY), 64'(0));
        chk("rst_dev_req", 64'(oDEV_REQ), 64'(0));
        chk("rst_irq_req", 64'(oDPS_IRQ_REQ), 64'(0));
        chk("rst_irq_num", 64'(oDPS_IRQ_NUM), 64'(BASE));
        chk("rst_irq_ack", 64'(oDEV_IRQ_ACK), 64'(0));
        tick(); tick();
        inRESET = 1'b1;
        tick();

        // Decode / accept table, each vector applied from IDLE
        vecs[0] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'b0000, 1'b0, 4'b0001, 6'h00, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_03FC, 32'h1111_2222, 4'b0000, 1'b0, 4'b1000, 6'h3F, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0400, 32'h3333_4444, 4'b0000, 1'b0, 4'b0000, 6'h00, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 1'b0, 4'b0000, 6'h00, 1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FF07, 32'h0,         4'b0000, 1'b0, 4'b0000, 6'h01, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0207, 32'h5555_6666, 4'b0100, 1'b1, 4'b0000, 6'h01, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0104, 32'h0,         4'b1000, 1'b1, 4'b0000, 6'h01, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_02F0, 32'h7777_8888, 4'b0000, 1'b0, 4'b0100, 6'h3C, 1'b0};
        for (int i = 0; i < 8; i++) begin
            iDPS_REQ  = 1'b1;
            iDPS_RW   = vecs[i].rw;
            iDPS_ADDR = vecs[i].addr;
            iDPS_DATA = vecs[i].wdata;
            iDEV_BUSY = vecs[i].devBusy;
            #1;
            chk("tbl_busy", 64'(oDPS_BUSY), 64'(vecs[i].expBusy));
            chk("tbl_dev_req", 64'(oDEV_REQ), 64'(vecs[i].expReq));
            chk("tbl_dev_addr", 64'(oDEV_ADDR), 64'(vecs[i].expAddr));
            tick();
            iDPS_REQ  = 1'b0;
            iDEV_BUSY = '0;
            chk("tbl_rsp_valid", 64'(oDPS_VALID), 64'(vecs[i].expRsp));
            if (vecs[i].expRsp) begin
                chk("tbl_rsp_err", 64'(oDPS_ERR), 64'(1));
                chk("tbl_rsp_data", 64'(oDPS_DATA), 64'(0));
            end
            tick();
            chk("tbl_valid_pulse", 64'(oDPS_VALID), 64'(0));
            chk("tbl_back_idle", 64'(oDPS_BUSY), 64'(0));
        end

        // Directed reads: normal, unmapped, timeout with late reply, valid-wins boundary
        doRead(32'h0000_0104, 3, 32'hCAFE_0001);
        doRead(32'h0000_0400, 0, 32'h0);
        doWrite(32'h0000_0400, 32'hDEAD_BEEF);
        doRead(32'h0000_0200, TMO + 2, 32'h0BAD_0BAD);
        doRead(32'h0000_0208, 4, 32'h1234_5678);
        doRead(32'h0000_0300, TMO - 1, 32'h600D_0007);
        doRead(32'h0000_0004, TMO, 32'h1A7E_1A7E);

        // Busy slot blocks acceptance until it drops
        iDEV_BUSY = 4'b1000;
        iDPS_REQ  = 1'b1;
        iDPS_RW   = 1'b0;
        iDPS_ADDR = 32'h0000_0104;
        #1;
        chk("busy_blocks", 64'(oDPS_BUSY), 64'(1));
        chk("busy_no_req", 64'(oDEV_REQ), 64'(0));
        tick();
        chk("busy_still", 64'(oDPS_BUSY), 64'(1));
        chk("busy_no_rsp", 64'(oDPS_VALID), 64'(0));
        iDEV_BUSY = '0;
        doRead(32'h0000_0104, 1, 32'hBEEF_0002);

        // Round-robin over slots 1 and 3
        expNum[0] = 6'h37; expNum[1] = 6'h39; expNum[2] = 6'h37;
        expAck[0] = 4'b0010; expAck[1] = 4'b1000; expAck[2] = 4'b0010;
        iDEV_IRQ = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rr_req", 64'(oDPS_IRQ_REQ), 64'(1));
            chk("rr_num", 64'(oDPS_IRQ_NUM), 64'(expNum[j]));
            chk("rr_no_ack_yet", 64'(oDEV_IRQ_ACK), 64'(0));
            iDPS_IRQ_ACK = 1'b1;
            if (j == 2) iDEV_IRQ = '0;
            tick();
            iDPS_IRQ_ACK = 1'b0;
            chk("rr_ack", 64'(oDEV_IRQ_ACK), 64'(expAck[j]));
            chk("rr_req_drop", 64'(oDPS_IRQ_REQ), 64'(0));
        end
        rrModel = 2;
        iDPS_IRQ_ACK = 1'b1;
        tick();
        iDPS_IRQ_ACK = 1'b0;
        chk("idle_ack_ignored", 64'(oDEV_IRQ_ACK), 64'(0));
        chk("idle_ack_no_req", 64'(oDPS_IRQ_REQ), 64'(0));

        // Reset during RD_WAIT and IRQ_WAIT
        iDEV_IRQ  = 4'b1010;
        iDPS_REQ  = 1'b1;
        iDPS_RW   = 1'b0;
        iDPS_ADDR = 32'h0000_0200;
        tick();
        iDPS_REQ = 1'b0;
        chk("pre_rst_irq_req", 64'(oDPS_IRQ_REQ), 64'(1));
        chk("pre_rst_irq_num", 64'(oDPS_IRQ_NUM), 64'(6'h39));
        chk("pre_rst_busy", 64'(oDPS_BUSY), 64'(1));
        tick();
        inRESET = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(oDPS_VALID), 64'(0));
        chk("mid_rst_data", 64'(oDPS_DATA), 64'(0));
        chk("mid_rst_err", 64'(oDPS_ERR), 64'(0));
        chk("mid_rst_busy", 64'(oDPS_BUSY), 64'(0));
        chk("mid_rst_irq_req", 64'(oDPS_IRQ_REQ), 64'(0));
        chk("mid_rst_irq_num", 64'(oDPS_IRQ_NUM), 64'(BASE));
        chk("mid_rst_irq_ack", 64'(oDEV_IRQ_ACK), 64'(0));
        tick();
        inRESET  = 1'b1;
        iDEV_IRQ = 4'b1111;
        tick();
        chk("post_rst_ptr0", 64'(oDPS_IRQ_NUM), 64'(BASE));
        chk("post_rst_irq_req", 64'(oDPS_IRQ_REQ), 64'(1));
        chk("post_rst_no_rsp", 64'(oDPS_VALID), 64'(0));
        iDPS_IRQ_ACK = 1'b1;
        iDEV_IRQ     = '0;
        tick();
        iDPS_IRQ_ACK = 1'b0;
        chk("post_rst_ack", 64'(oDEV_IRQ_ACK), 64'(4'b0001));
        rrModel = 1;
        doRead(32'h0000_020C, 2, 32'h5A5A_1234);

        // Concurrent random access traffic and IRQ traffic
        fork
            accessRandom(40);
            irqRandom(20);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
